grf_wport_arbiter: RTL and testbench
====================================

Name: grf_wport_arbiter

Overview:
Shares the single GRF write port between the pipeline writeback stage (WB) and an auxiliary multi-cycle unit (AUX, e.g. mult/div result writeback). WB always has priority. AUX results queue in a small FIFO and drain in idle WB cycles. A starvation counter requests a pipeline stall when AUX is held off too long. The block also flags decode-stage reads of registers still pending in the FIFO, so hazard logic can stall.

Parameters:
DEPTH, 2, AUX FIFO entries; power of two, >=2.
STARVE_MAX, 4, consecutive WB-won cycles with a non-empty FIFO before stall_req asserts.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high; clears all state immediately.
wb_we  input  1  WB write request; never back-pressured.
wb_addr  input  5  WB destination register.
wb_data  input  32  WB write data.
wb_pc  input  32  PC of the WB instruction, for GRF trace.
aux_valid  input  1  AUX result valid.
aux_addr  input  5  AUX destination register.
aux_data  input  32  AUX write data.
aux_pc  input  32  PC of the originating AUX instruction.
aux_ready  output  1  FIFO can accept an entry; equals (count < DEPTH), from registered count only.
rd_rs  input  5  decode-stage rs read address.
rd_rt  input  5  decode-stage rt read address.
pend_hit  output  1  rd_rs or rd_rt (nonzero) matches the address of a valid FIFO entry.
stall_req  output  1  request to pipeline: insert a WB bubble.
RegWrite  output  1  registered GRF write enable.
RegAddr  output  5  registered GRF write address.
RegData  output  32  registered GRF write data.
reg_pc  output  32  registered PC of the granted write.

Behaviour:
- Reset, asynchronous: RegWrite=0, RegAddr=0, RegData=0, reg_pc=0, FIFO count=0, read/write pointers=0, starve_cnt=0. As a result aux_ready=1, stall_req=0, pend_hit=0. Any in-flight FIFO entries are discarded.
- Enqueue occurs when aux_valid && aux_ready at a posedge. Data, address and PC are stored at the tail.
  - aux_addr==0: the handshake completes (accepted) but nothing is stored; the entry is dropped.
- Arbitration is decided each cycle from the current inputs and FIFO state. The result is registered at posedge, so outputs have 1-cycle latency:
  - wb_we=1: grant WB; next RegWrite=1, RegAddr/RegData/reg_pc = wb_*. WB address 0 passes through; the GRF ignores it.
  - else if count>0: grant the FIFO head; pop it; outputs take the head fields with RegWrite=1.
  - else: RegWrite=0; RegAddr/RegData/reg_pc hold their previous values.
- AUX latency: an entry accepted at edge N is granted at the earliest in the cycle after N, so RegWrite is asserted at the earliest after edge N+1. There is no bypass around the FIFO.
- Same-cycle enqueue and pop are allowed. count is unchanged; aux_ready is still computed from the pre-edge count, so a full FIFO refuses even if it pops that cycle.
- FIFO order is strict. Two entries to the same register retire in arrival order; the last one wins.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never over- or underflows.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on every edge where count>0 && wb_we.
  - Clears on any FIFO pop or when count==0.
  - stall_req = (starve_cnt == STARVE_MAX), combinational from the register. It stays high until the next pop.
  - If wb_we is still 1 while stall_req=1, WB still wins; stall_req stays asserted.
- pend_hit is combinational over valid entries only, with address 0 excluded. The output register is not checked, because the GRF bypasses RegData internally.
- Reset asserted mid-drain: RegWrite drops to 0 immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle: RegWrite=0, aux_ready=1, stall_req=0, pend_hit=0. Assert reset mid-cycle with count=2 -> count=0 and RegWrite=0 immediately.
- wb_we=1, wb_addr=5, wb_data=0x1234, wb_pc=0x3000 for one cycle -> next cycle RegWrite=1, RegAddr=5, RegData=0x1234, reg_pc=0x3000; the cycle after, RegWrite=0.
- AUX write addr=8, data=0xDEAD accepted at edge N with WB idle -> RegWrite=1, RegAddr=8 after edge N+1. With rd_rs=8 during cycle N+1 (entry still queued) -> pend_hit=1.
- Two AUX writes to reg 9 (0x1, then 0x2), then a third with the FIFO full -> aux_ready=0 on the third. Drain order is 0x1 then 0x2. An aux_addr=0 write is accepted but no GRF write is issued.
- FIFO holds 1 entry, wb_we=1 continuously -> stall_req=1 after 4 WB-won edges. Drop wb_we for one cycle -> entry retires and stall_req returns to 0.
- AUX enqueue and FIFO pop in the same cycle at count=1 -> count stays 1. Outputs show the old head; the new entry retires on the next idle-WB cycle.

Source files
------------

// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: WB has absolute priority, AUX results queue in a
// small FIFO and drain in WB-idle cycles. A starvation counter requests a WB
// bubble, and decode reads of still-queued destinations are flagged.
module grf_wport_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        aux_valid,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    input  logic [31:0] aux_pc,
    output logic        aux_ready,
    input  logic [4:0]  rd_rs,
    input  logic [4:0]  rd_rt,
    output logic        pend_hit,
    output logic        stall_req,
    output logic        RegWrite,
    output logic [4:0]  RegAddr,
    output logic [31:0] RegData,
    output logic [31:0] reg_pc
);

    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned StW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [StW-1:0]  starve_q, starve_d;

    logic [4:0]  mem_addr_q [DEPTH];
    logic [4:0]  mem_addr_d [DEPTH];
    logic [31:0] mem_data_q [DEPTH];
    logic [31:0] mem_data_d [DEPTH];
    logic [31:0] mem_pc_q   [DEPTH];
    logic [31:0] mem_pc_d   [DEPTH];

    logic        reg_write_q, reg_write_d;
    logic [4:0]  reg_addr_q,  reg_addr_d;
    logic [31:0] reg_data_q,  reg_data_d;
    logic [31:0] reg_pc_q,    reg_pc_d;

    logic fifo_empty;
    logic push;
    logic pop;

    // Handshake and FIFO control; address-0 results are accepted but never stored.
    always_comb begin
        fifo_empty = (count_q == '0);
        aux_ready  = (count_q < CntW'(DEPTH));
        push       = aux_valid && aux_ready && (aux_addr != 5'd0);
        pop        = !wb_we && !fifo_empty;
        stall_req  = (starve_q == StW'(STARVE_MAX));
    end

    // FIFO storage, pointer and occupancy next-state.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_pc_d   = mem_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = aux_addr;
            mem_data_d[wr_ptr_q] = aux_data;
            mem_pc_d[wr_ptr_q]   = aux_pc;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port arbitration: WB first, otherwise drain the FIFO head.
    always_comb begin
        reg_write_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        reg_pc_d    = reg_pc_q;
        if (wb_we) begin
            reg_write_d = 1'b1;
            reg_addr_d  = wb_addr;
            reg_data_d  = wb_data;
            reg_pc_d    = wb_pc;
        end else if (!fifo_empty) begin
            reg_write_d = 1'b1;
            reg_addr_d  = mem_addr_q[rd_ptr_q];
            reg_data_d  = mem_data_q[rd_ptr_q];
            reg_pc_d    = mem_pc_q[rd_ptr_q];
        end
    end

    // Starvation counter: counts WB-won edges while AUX work is waiting.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (wb_we && (starve_q != StW'(STARVE_MAX))) begin
            starve_d = starve_q + StW'(1);
        end
    end

    // Pending-read hazard: compare decode addresses against occupied slots only.
    always_comb begin
        logic [PtrW-1:0] offset;
        pend_hit = 1'b0;
        offset   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PtrW'(i) - rd_ptr_q;
            if (CntW'(offset) < count_q) begin
                if ((rd_rs != 5'd0) && (rd_rs == mem_addr_q[i])) pend_hit = 1'b1;
                if ((rd_rt != 5'd0) && (rd_rt == mem_addr_q[i])) pend_hit = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= 5'd0;
            reg_data_q  <= 32'd0;
            reg_pc_q    <= 32'd0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= 5'd0;
                mem_data_q[i] <= 32'd0;
                mem_pc_q[i]   <= 32'd0;
            end
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            reg_pc_q    <= reg_pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_pc_q    <= mem_pc_d;
        end
    end

    assign RegWrite = reg_write_q;
    assign RegAddr  = reg_addr_q;
    assign RegData  = reg_data_q;
    assign reg_pc   = reg_pc_q;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter with hand-computed expectations.
module tb_grf_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        aux_valid;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic [31:0] aux_pc;
    logic        aux_ready;
    logic [4:0]  rd_rs;
    logic [4:0]  rd_rt;
    logic        pend_hit;
    logic        stall_req;
    logic        RegWrite;
    logic [4:0]  RegAddr;
    logic [31:0] RegData;
    logic [31:0] reg_pc;

    int total = 0;
    int bad   = 0;

    grf_wport_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_pc     (wb_pc),
        .aux_valid (aux_valid),
        .aux_addr  (aux_addr),
        .aux_data  (aux_data),
        .aux_pc    (aux_pc),
        .aux_ready (aux_ready),
        .rd_rs     (rd_rs),
        .rd_rt     (rd_rt),
        .pend_hit  (pend_hit),
        .stall_req (stall_req),
        .RegWrite  (RegWrite),
        .RegAddr   (RegAddr),
        .RegData   (RegData),
        .reg_pc    (reg_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs changed here hold until the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_set(input logic we, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] pc);
        wb_we = we; wb_addr = a; wb_data = d; wb_pc = pc;
    endtask

    task automatic aux_set(input logic v, input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] pc);
        aux_valid = v; aux_addr = a; aux_data = d; aux_pc = pc;
    endtask

    initial begin
        reset = 1'b1;
        wb_set(1'b0, 5'd0, 32'd0, 32'd0);
        aux_set(1'b0, 5'd0, 32'd0, 32'd0);
        rd_rs = 5'd0;
        rd_rt = 5'd0;
        #22 reset = 1'b0;
        #1;

        // Reset state.
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_regaddr", RegAddr, 0);
        chk("rst_regdata", RegData, 0);
        chk("rst_regpc", reg_pc, 0);
        chk("rst_ready", aux_ready, 1);
        chk("rst_stall", stall_req, 0);
        chk("rst_pend", pend_hit, 0);

        // Single WB write, 1-cycle latency.
        wb_set(1'b1, 5'd5, 32'h1234, 32'h3000);
        tick();
        wb_set(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        chk("wb_we", RegWrite, 1);
        chk("wb_addr", RegAddr, 5);
        chk("wb_data", RegData, 32'h1234);
        chk("wb_pc", reg_pc, 32'h3000);
        tick();
        chk("wb_idle_we", RegWrite, 0);
        chk("wb_idle_hold_addr", RegAddr, 5);
        chk("wb_idle_hold_data", RegData, 32'h1234);

        // AUX write: queued at edge N, hazard visible, retires after N+1.
        aux_set(1'b1, 5'd8, 32'hDEAD, 32'h4000);
        tick();
        aux_set(1'b0, 5'd0, 32'd0, 32'd0);
        rd_rs = 5'd8;
        #1;
        chk("aux_pend", pend_hit, 1);
        chk("aux_no_bypass", RegWrite, 0);
        tick();
        chk("aux_we", RegWrite, 1);
        chk("aux_addr", RegAddr, 8);
        chk("aux_data", RegData, 32'hDEAD);
        chk("aux_pc", reg_pc, 32'h4000);
        chk("aux_pend_clear", pend_hit, 0);
        rd_rs = 5'd0;

        // Fill FIFO under WB pressure, third entry refused, strict drain order.
        wb_set(1'b1, 5'd1, 32'h55, 32'h10);
        aux_set(1'b1, 5'd9, 32'h1, 32'h100);
        tick();
        aux_set(1'b1, 5'd9, 32'h2, 32'h104);
        tick();
        aux_set(1'b1, 5'd9, 32'h3, 32'h108);
        #1;
        chk("full_ready", aux_ready, 0);
        chk("full_wb_wins", RegAddr, 1);
        tick();
        wb_set(1'b0, 5'd0, 32'd0, 32'd0);
        aux_set(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        chk("full_stall_low", stall_req, 0);
        tick();
        chk("drain0_addr", RegAddr, 9);
        chk("drain0_data", RegData, 32'h1);
        tick();
        chk("drain1_data", RegData, 32'h2);
        chk("drain1_pc", reg_pc, 32'h104);
        tick();
        chk("refused_not_queued", RegWrite, 0);
        chk("drained_ready", aux_ready, 1);

        // Address-0 AUX result: accepted, never written.
        aux_set(1'b1, 5'd0, 32'h77, 32'h200);
        #1;
        chk("zero_ready", aux_ready, 1);
        tick();
        aux_set(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("zero_no_write", RegWrite, 0);

        // Starvation: one queued entry, WB continuously busy.
        wb_set(1'b1, 5'd2, 32'hAA, 32'h20);
        aux_set(1'b1, 5'd10, 32'hBEEF, 32'h300);
        tick();
        aux_set(1'b0, 5'd0, 32'd0, 32'd0);
        for (int k = 1; k <= 3; k++) tick();
        chk("starve3_low", stall_req, 0);
        tick();
        chk("starve4_high", stall_req, 1);
        tick();
        chk("starve_sat_high", stall_req, 1);
        chk("starve_wb_wins", RegAddr, 2);
        wb_set(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("starve_retire_addr", RegAddr, 10);
        chk("starve_retire_data", RegData, 32'hBEEF);
        chk("starve_clear", stall_req, 0);

        // Enqueue and pop in the same cycle at count=1.
        wb_set(1'b1, 5'd3, 32'hCC, 32'h30);
        aux_set(1'b1, 5'd11, 32'h111, 32'h400);
        tick();
        wb_set(1'b0, 5'd0, 32'd0, 32'd0);
        aux_set(1'b1, 5'd12, 32'h222, 32'h404);
        tick();
        aux_set(1'b0, 5'd0, 32'd0, 32'd0);
        rd_rt = 5'd12;
        #1;
        chk("same_old_head", RegAddr, 11);
        chk("same_old_data", RegData, 32'h111);
        chk("same_ready", aux_ready, 1);
        chk("same_pend_rt", pend_hit, 1);
        tick();
        chk("same_new_addr", RegAddr, 12);
        chk("same_new_data", RegData, 32'h222);
        rd_rt = 5'd0;
        tick();
        chk("same_empty", RegWrite, 0);

        // Mid-cycle asynchronous reset with two entries queued.
        wb_set(1'b1, 5'd4, 32'hDD, 32'h40);
        aux_set(1'b1, 5'd13, 32'h333, 32'h500);
        tick();
        tick();
        aux_set(1'b0, 5'd0, 32'd0, 32'd0);
        rd_rs = 5'd13;
        #1;
        chk("pre_rst_full", aux_ready, 0);
        chk("pre_rst_pend", pend_hit, 1);
        chk("pre_rst_we", RegWrite, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_we", RegWrite, 0);
        chk("async_rst_ready", aux_ready, 1);
        chk("async_rst_pend", pend_hit, 0);
        wb_set(1'b0, 5'd0, 32'd0, 32'd0);
        #1 reset = 1'b0;
        tick();
        tick();
        chk("post_rst_discard", RegWrite, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
